// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer with stall/redirect/halt handling and fetch counter
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   trigger           start/resume pulse, honoured only in IDLE and HALT
//   ImemReady         instruction memory has valid data for the presented PC
//   StallD            hold PC and F/D register
//   PCSrcE            execute-stage redirect (taken branch/jump)
//   HaltD             halt instruction sitting in decode
//   ImemReq           fetch request to instruction memory
//   PCEnF, RegFEn     PC and F/D register load enables
//   FlushD, FlushE    bubble into F/D and D/E registers
//   Running, Halted   state indicators
//   FetchCount        saturating count of accepted fetches

module fetch_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 trigger,
  input  logic                 ImemReady,
  input  logic                 StallD,
  input  logic                 PCSrcE,
  input  logic                 HaltD,
  output logic                 ImemReq,
  output logic                 PCEnF,
  output logic                 RegFEn,
  output logic                 FlushD,
  output logic                 FlushE,
  output logic                 Running,
  output logic                 Halted,
  output logic [CNT_WIDTH-1:0] FetchCount
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                 state_q, state_d;
  logic   [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   accept;

  // Redirect outranks stall, stall outranks halt, halt outranks the memory response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    ImemReq = 1'b0;
    PCEnF   = 1'b0;
    RegFEn  = 1'b1;
    FlushD  = 1'b1;
    FlushE  = 1'b0;
    Running = 1'b0;
    Halted  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trigger) state_d = S_FETCH;
      end
      S_HALT: begin
        Halted = 1'b1;
        if (trigger) state_d = S_FETCH;
      end
      S_FETCH: begin
        ImemReq = 1'b1;
        Running = 1'b1;
        if (PCSrcE) begin
          // Memory restarts on the PC change; no squash tracking needed.
          PCEnF  = 1'b1;
          FlushE = 1'b1;
        end else if (StallD) begin
          RegFEn = 1'b0;
          FlushD = 1'b0;
        end else if (HaltD) begin
          // PC held so a resume refetches the instruction after the halt.
          state_d = S_HALT;
        end else if (ImemReady) begin
          PCEnF  = 1'b1;
          FlushD = 1'b0;
          accept = 1'b1;
        end
        // Otherwise waiting: bubble into decode, PC held.
      end
      default: state_d = S_IDLE;
    endcase
    if (accept && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign FetchCount = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl against a behavioural model

module tb_fetch_ctrl;

  logic clk = 1'b0;
  logic reset, trigger, ImemReady, StallD, PCSrcE, HaltD;
  logic ImemReq, PCEnF, RegFEn, FlushD, FlushE, Running, Halted;
  logic [31:0] FetchCount;
  logic ImemReq3, PCEnF3, RegFEn3, FlushD3, FlushE3, Running3, Halted3;
  logic [2:0] FetchCount3;

  always #5 clk = ~clk;

  fetch_ctrl #(.CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .trigger(trigger), .ImemReady(ImemReady),
    .StallD(StallD), .PCSrcE(PCSrcE), .HaltD(HaltD),
    .ImemReq(ImemReq), .PCEnF(PCEnF), .RegFEn(RegFEn), .FlushD(FlushD),
    .FlushE(FlushE), .Running(Running), .Halted(Halted), .FetchCount(FetchCount)
  );

  fetch_ctrl #(.CNT_WIDTH(3)) dut3 (
    .clk(clk), .reset(reset), .trigger(trigger), .ImemReady(ImemReady),
    .StallD(StallD), .PCSrcE(PCSrcE), .HaltD(HaltD),
    .ImemReq(ImemReq3), .PCEnF(PCEnF3), .RegFEn(RegFEn3), .FlushD(FlushD3),
    .FlushE(FlushE3), .Running(Running3), .Halted(Halted3), .FetchCount(FetchCount3)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: mode 0=idle, 1=fetching, 2=halted; counts as plain integers.
  int              m_mode = 0, n_mode = 0;
  longint unsigned m_cnt = 0, n_cnt = 0, m_cnt3 = 0, n_cnt3 = 0;
  bit              m_valid = 0, n_valid = 0;

  // {ImemReq, PCEnF, RegFEn, FlushD, FlushE, Running, Halted}
  function automatic logic [6:0] expect_ctl();
    if (m_mode != 1) return {6'b001100, (m_mode == 2) ? 1'b1 : 1'b0};
    if (PCSrcE)      return 7'b1111110;
    if (StallD)      return 7'b1000010;
    if (HaltD)       return 7'b1011010;
    if (ImemReady)   return 7'b1110010;
    return 7'b1011010;
  endfunction

  always @(negedge clk) begin
    bit acc;
    if (m_valid) begin
      chk("ctl32", {ImemReq, PCEnF, RegFEn, FlushD, FlushE, Running, Halted}, expect_ctl());
      chk("ctl3", {ImemReq3, PCEnF3, RegFEn3, FlushD3, FlushE3, Running3, Halted3}, expect_ctl());
      chk("count32", FetchCount, m_cnt);
      chk("count3", FetchCount3, m_cnt3);
    end
    n_mode = m_mode; n_cnt = m_cnt; n_cnt3 = m_cnt3; n_valid = m_valid;
    if (reset) begin
      n_mode = 0; n_cnt = 0; n_cnt3 = 0; n_valid = 1;
    end else if (m_mode != 1) begin
      if (trigger) n_mode = 1;
    end else begin
      acc = !PCSrcE && !StallD && !HaltD && ImemReady;
      if (!PCSrcE && !StallD && HaltD) n_mode = 2;
      if (acc) begin
        n_cnt  = (m_cnt  == 64'hFFFF_FFFF) ? m_cnt  : m_cnt + 1;
        n_cnt3 = (m_cnt3 == 64'd7)         ? m_cnt3 : m_cnt3 + 1;
      end
    end
  end

  always @(posedge clk) begin
    m_mode = n_mode; m_cnt = n_cnt; m_cnt3 = n_cnt3; m_valid = n_valid;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    trigger = 0; StallD = 0; PCSrcE = 0; HaltD = 0;
  endtask

  initial begin
    reset = 1; clr(); ImemReady = 0;
    cyc(2);
    reset = 0; ImemReady = 1;
    cyc(5);
    chk("idle_count", FetchCount, 0);
    chk("idle_running", Running, 0);
    trigger = 1; cyc(1); trigger = 0;
    chk("start_running", Running, 1);
    cyc(4);
    chk("four_fetches", FetchCount, 4);
    ImemReady = 0; cyc(2); ImemReady = 1; cyc(1);
    chk("wait_then_accept", FetchCount, 5);
    StallD = 1; cyc(1);
    PCSrcE = 1; cyc(1);
    clr();
    chk("stall_redirect_count", FetchCount, 5);
    HaltD = 1; cyc(1); HaltD = 0;
    chk("halted", Halted, 1);
    chk("halt_no_req", ImemReq, 0);
    cyc(2);
    trigger = 1; cyc(1); trigger = 0;
    chk("resume_halted", Halted, 0);
    cyc(1);
    chk("resume_fetch", FetchCount, 6);
    HaltD = 1; PCSrcE = 1; cyc(1); clr();
    chk("redirect_beats_halt", {Running, Halted}, 2'b10);
    cyc(10);
    chk("sat3", FetchCount3, 7);
    chk("count16", FetchCount, 16);
    cyc(2);
    chk("sat3_hold", FetchCount3, 7);
    ImemReady = 0; cyc(1);
    reset = 1; cyc(1); reset = 0;
    chk("reset_count", FetchCount, 0);
    chk("reset_req", ImemReq, 0);
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 99) < 1);
      trigger   = ($urandom_range(0, 99) < 10);
      StallD    = ($urandom_range(0, 99) < 20);
      PCSrcE    = ($urandom_range(0, 99) < 10);
      HaltD     = ($urandom_range(0, 99) < 4);
      ImemReady = ($urandom_range(0, 99) < 60);
      cyc(1);
    end
    reset = 0; clr();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencer for the instruction-fetch stage of the pipelined RISC-V core. It starts the core on `trigger` and sequences PC and F/D-register updates against a variable-latency instruction-memory handshake. It applies decode stalls, execute-stage redirects and halt instructions, and keeps a fetch counter. It sits beside the PC, instruction memory and F/D pipeline register and drives their enables and flushes.

Parameters:
CNT_WIDTH, 32, width of the accepted-fetch counter FetchCount.

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
trigger  input  1  start/resume pulse; ignored outside IDLE/HALT
ImemReady  input  1  instruction memory: InstrF valid for the PCF presented this cycle
StallD  input  1  hazard unit: hold the F/D register and PC
PCSrcE  input  1  execute stage: taken branch/jump; PC loads PCTargetE
HaltD  input  1  decode holds a halt instruction
ImemReq  output  1  fetch request to instruction memory
PCEnF  output  1  PC register load enable
RegFEn  output  1  F/D register load enable
FlushD  output  1  load a bubble (NOP) into the F/D register
FlushE  output  1  load a bubble into the D/E register
Running  output  1  state == FETCH
Halted  output  1  state == HALT
FetchCount  output  CNT_WIDTH  number of accepted fetches, saturating

Behaviour:
- States: IDLE (reset), FETCH, HALT. Encoding is free. Control outputs are combinational from state and inputs. State and FetchCount are registered.
- Reset, sync, highest priority, legal mid-access:
  - state=IDLE, FetchCount=0.
  - Outputs then read: ImemReq=0, PCEnF=0, RegFEn=1, FlushD=1, FlushE=0, Running=0, Halted=0.
- IDLE:
  - Outputs as at reset.
  - trigger=1 -> FETCH next cycle.
  - Other inputs are ignored.
- FETCH: ImemReq=1. Per-cycle priority: PCSrcE > StallD > HaltD > ImemReady.
  - PCSrcE=1 (redirect): PCEnF=1, RegFEn=1, FlushD=1, FlushE=1. No count. The memory restarts its access on the PC change, so no squash state is kept.
  - StallD=1: PCEnF=0, RegFEn=0, FlushD=0. No count.
  - HaltD=1: PCEnF=0, RegFEn=1, FlushD=1. No count. Go to HALT. PCF is held, so a resume refetches the instruction after the halt.
  - ImemReady=1 (accept): PCEnF=1, RegFEn=1, FlushD=0. FetchCount+1.
  - ImemReady=0 (wait): PCEnF=0, RegFEn=1, FlushD=1, so a bubble enters decode while waiting.
  - FlushE=0 in every FETCH case except redirect.
- HALT:
  - Outputs: ImemReq=0, PCEnF=0, RegFEn=1, FlushD=1, FlushE=0, Halted=1.
  - trigger=1 -> FETCH next cycle.
  - PCSrcE and HaltD are ignored.
- Memory contract: InstrF and ImemReady stay stable while PCF is unchanged and ImemReq=1. A same-cycle ready (combinational ROM, ImemReady tied 1) is legal and gives one fetch per cycle.
- FetchCount saturates at 2^CNT_WIDTH-1. It does not wrap.
- trigger held high is level-tolerant: in FETCH it has no effect.

Test Plan:
- Reset, then 5 cycles with trigger=0 and ImemReady=1 -> ImemReq=0, PCEnF=0, FlushD=1, Running=0, FetchCount=0 throughout.
- Pulse trigger, ImemReady tied 1 -> Running=1 from the next cycle, PCEnF=1 every cycle, FetchCount=4 after 4 FETCH cycles.
- In FETCH, ImemReady sequence 0,0,1 -> PCEnF=0,0,1 and FlushD=1,1,0; FetchCount increments by exactly 1.
- StallD=1 with ImemReady=1 -> PCEnF=0, RegFEn=0, FlushD=0, count unchanged. Next cycle StallD=1 and PCSrcE=1 together -> PCEnF=1, FlushD=1, FlushE=1, count unchanged.
- HaltD=1 and ImemReady=1 in the same cycle -> PCEnF=0, FlushD=1, Halted=1 next cycle, ImemReq=0. Pulse trigger -> FETCH, Halted=0, first accepted fetch uses the held PC. Same test with HaltD=1 and PCSrcE=1 together -> redirect, no halt.
- Run with CNT_WIDTH=3 for 10 accepts -> FetchCount reads 7 and holds. Assert reset mid-wait (ImemReady=0) -> IDLE, FetchCount=0, ImemReq=0 next cycle.
